// File: rtl/regs_ctrl.sv
// Register file port controller: post-reset zero-fill of x1..x31, arbitration
// of the write port and read port B between pipeline writeback and an
// auxiliary requester, and write-to-read bypass around the registered,
// read-first register file array.
module regs_ctrl #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_dat_rd_a,
  output logic [DATA_W-1:0] o_dat_rd_b,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_dat,
  input  logic              i_aux_valid,
  input  logic              i_aux_we,
  input  logic [ADDR_W-1:0] i_aux_addr,
  input  logic [DATA_W-1:0] i_aux_dat,
  output logic              o_aux_ready,
  output logic              o_aux_done,
  output logic [DATA_W-1:0] o_aux_rdata,
  output logic              o_stall,
  output logic              o_rf_ce,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_addr_wr,
  output logic [DATA_W-1:0] o_rf_dat_wr,
  output logic [ADDR_W-1:0] o_rf_addr_rd_a,
  output logic [ADDR_W-1:0] o_rf_addr_rd_b,
  input  logic [DATA_W-1:0] i_rf_dat_rd_a,
  input  logic [DATA_W-1:0] i_rf_dat_rd_b
);

  localparam logic [1:0] S_CLEAR   = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_AUX_ACK = 2'd2;

  localparam logic [1:0]        RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
  localparam logic [ADDR_W-1:0] CNT_INIT  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              weff;
  logic              z_a;
  logic              z_b;
  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] byp;

  // Port A always follows the pipeline.
  assign o_rf_addr_rd_a = i_rd_addr_a;

  // Port steering and next-state selection.
  always_comb begin
    state_nxt      = state;
    o_stall        = 1'b1;
    o_aux_ready    = 1'b0;
    o_rf_ce        = 1'b0;
    o_rf_we        = 1'b0;
    o_rf_addr_wr   = i_wb_addr;
    o_rf_dat_wr    = i_wb_dat;
    o_rf_addr_rd_b = i_rd_addr_b;
    case (state)
      S_CLEAR: begin
        o_rf_ce      = 1'b1;
        o_rf_we      = 1'b1;
        o_rf_addr_wr = cnt;
        o_rf_dat_wr  = '0;
        if (cnt == '1) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        o_stall     = 1'b0;
        o_aux_ready = i_aux_valid & ~i_ce;
        if (o_aux_ready) begin
          // Aux owns the array this cycle; the pipeline is frozen so
          // there is no writeback to collide with.
          state_nxt = S_AUX_ACK;
          o_rf_ce   = 1'b1;
          if (i_aux_we) begin
            o_rf_we      = 1'b1;
            o_rf_addr_wr = i_aux_addr;
            o_rf_dat_wr  = i_aux_dat;
          end else begin
            o_rf_addr_rd_b = i_aux_addr;
          end
        end else begin
          o_rf_ce = i_ce;
          o_rf_we = i_wb_we;
        end
      end
      S_AUX_ACK: begin
        // Enable the array so port B re-reads the pipeline address and the
        // pipeline sees its own data again once it resumes.
        o_rf_ce   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign weff        = o_rf_ce & o_rf_we & (o_rf_addr_wr != '0);
  assign o_aux_done  = (state == S_AUX_ACK);
  assign o_aux_rdata = o_dat_rd_b;

  assign o_dat_rd_a = z_a ? '0 : (hit_a ? byp : i_rf_dat_rd_a);
  assign o_dat_rd_b = z_b ? '0 : (hit_b ? byp : i_rf_dat_rd_b);

  // State register and zero-fill address counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RST_STATE;
      cnt   <= CNT_INIT;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  // Bypass flags track the addresses actually presented to the array.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      z_a   <= 1'b0;
      z_b   <= 1'b0;
      hit_a <= 1'b0;
      hit_b <= 1'b0;
      byp   <= '0;
    end else begin
      z_a   <= (o_rf_addr_rd_a == '0);
      z_b   <= (o_rf_addr_rd_b == '0);
      hit_a <= weff & (o_rf_addr_wr == o_rf_addr_rd_a);
      hit_b <= weff & (o_rf_addr_wr == o_rf_addr_rd_b);
      byp   <= o_rf_dat_wr;
    end
  end

endmodule

// File: doc/regs_ctrl.md
Name: regs_ctrl

Overview:
Port controller sitting between the CPU pipeline and the 32x32 synchronous-read register file.
- Sequences a zero-fill of x1..x31 after reset.
- Arbitrates the single write port and read port B between pipeline writeback and an auxiliary (debug/multicycle) requester.
- Provides write-to-read bypass, because the array read is registered and read-first.
- Asserts a stall while it owns the register file.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, register data width
CLEAR_ON_RESET, 1, 1 = run zero-fill sequence after reset; 0 = go straight to IDLE

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_ce  in  1  pipeline clock enable; the pipeline must gate it with !o_stall
i_rd_addr_a  in  ADDR_W  pipeline read address A
i_rd_addr_b  in  ADDR_W  pipeline read address B
o_dat_rd_a  out  DATA_W  bypassed read data A
o_dat_rd_b  out  DATA_W  bypassed read data B
i_wb_we  in  1  writeback write enable
i_wb_addr  in  ADDR_W  writeback address
i_wb_dat  in  DATA_W  writeback data
i_aux_valid  in  1  auxiliary request valid
i_aux_we  in  1  1 = write, 0 = read
i_aux_addr  in  ADDR_W  auxiliary address
i_aux_dat  in  DATA_W  auxiliary write data
o_aux_ready  out  1  request accepted this cycle
o_aux_done  out  1  one-cycle completion pulse
o_aux_rdata  out  DATA_W  read result, valid while o_aux_done is high for a read
o_stall  out  1  controller owns the register file
o_rf_ce, o_rf_we  out  1 each  register file enable and write enable
o_rf_addr_wr  out  ADDR_W  register file write address
o_rf_dat_wr  out  DATA_W  register file write data
o_rf_addr_rd_a, o_rf_addr_rd_b  out  ADDR_W each  register file read addresses
i_rf_dat_rd_a, i_rf_dat_rd_b  in  DATA_W each  register file registered read data

Behaviour:
State machine, states CLEAR / IDLE / AUX_ACK:
- i_rst asserted (any time): state = CLEAR if CLEAR_ON_RESET, else IDLE; clear counter = 1; o_aux_done = 0; bypass flags = 0.
- An in-flight aux transaction is abandoned on reset; no done pulse is produced.

CLEAR:
- Drive o_rf_ce = 1, o_rf_we = 1, o_rf_addr_wr = cnt, o_rf_dat_wr = 0.
- cnt increments by 1 each cycle. At cnt = 31, the next state is IDLE.
- CLEAR lasts exactly 31 cycles.
- o_stall = 1, o_aux_ready = 0. Writeback inputs are ignored.

IDLE:
- o_stall = 0.
- o_aux_ready = i_aux_valid & !i_ce, combinational. Aux is served only while the pipeline is frozen, so it never collides with writeback.
- Accept with i_aux_we = 1: o_rf_ce = 1, o_rf_we = 1, o_rf_addr_wr = i_aux_addr, o_rf_dat_wr = i_aux_dat.
- Accept with i_aux_we = 0: o_rf_addr_rd_b = i_aux_addr.
- Any accept moves the state to AUX_ACK.
- No accept: o_rf_ce = i_ce, o_rf_we = i_wb_we, write address/data = writeback fields, o_rf_addr_rd_b = i_rd_addr_b.

AUX_ACK:
- o_stall = 1, o_aux_ready = 0, o_aux_done = 1.
- o_aux_rdata = bypassed port-B data; its value is don't-care for writes.
- o_rf_addr_rd_b = i_rd_addr_b, which restores the pipeline's port-B data by the next cycle.
- Next state is IDLE unconditionally.

Read port A: o_rf_addr_rd_a = i_rd_addr_a at all times.

Effective write (weff): o_rf_ce & o_rf_we & (o_rf_addr_wr != 0).

Bypass (per port p, registered at each clock edge):
- z_p <= (rd_addr_p == 0)
- hit_p <= weff & (o_rf_addr_wr == rd_addr_p)
- byp <= o_rf_dat_wr
- Output: o_dat_rd_p = z_p ? 0 : hit_p ? byp : i_rf_dat_rd_p.
- rd_addr_p is the address actually driven to the register file.
- Result: a same-edge write and read of one register returns the new value with 1-cycle latency; x0 always reads 0.

Aux edge cases:
- Aux write to x0: accepted, no effect (o_rf_we may be 1, but the register file masks it), o_aux_done pulses.
- Aux read of x0: returns 0.
- i_aux_valid may be held across CLEAR; it is accepted in the first IDLE cycle with i_ce = 0.

Test Plan:
- CLEAR_ON_RESET=1, release i_rst -> o_stall high exactly 31 cycles, o_rf_addr_wr steps 1..31 with o_rf_dat_wr = 0; afterwards a read of x17 returns 0.
- i_ce=1, wb writes x5 = 0xDEADBEEF while i_rd_addr_a = 5, register file model read-first -> next cycle o_dat_rd_a = 0xDEADBEEF.
- wb writes x0 = 0x1234, then read x0 on both ports -> o_dat_rd_a = o_dat_rd_b = 0, no bypass hit.
- Sequence with i_ce=0 and i_rd_addr_b = 3 (x3 = 0x33):
  - Aux write x7 = 0xA5A5A5A5 -> ready same cycle, done next cycle.
  - Aux read x7 -> o_aux_rdata = 0xA5A5A5A5 with done.
  - Cycle after AUX_ACK -> o_dat_rd_b = 0x33.
- i_aux_valid=1 with i_ce=1 and wb writing x9 = 0x99 -> o_aux_ready = 0, register file write is x9 = 0x99, no aux write.
- Assert i_rst during AUX_ACK -> o_aux_done drops immediately, o_stall = 1, CLEAR restarts at address 1.
